gs232c_fetch_redirect_ctrl: RTL
===============================

Name: gs232c_fetch_redirect_ctrl

Overview:
- Sequences the instruction-fetch PC for the gs232c front end.
- Issues one 16-byte (4-instruction) fetch bundle per accepted request to the I-cache and tracks outstanding requests.
- Arbitrates redirects between the backend flush (highest priority), the predecode-stage cancel (pr_cancel/pr_target from the instruction judge) and sequential fetch.
- Drops wrong-path responses still in flight after a redirect.

Parameters:
- RESET_PC, 32'h1c000000, fetch address issued after reset.
- MAX_OUT, 4, maximum outstanding I-cache requests (1..7).
- CNT_W, 3, width of the outstanding and drop counters; must hold MAX_OUT.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- be_flush  in  1  backend redirect (exception or branch mispredict).
- be_target  in  32  backend redirect PC.
- pr_valid  in  1  predecode stage holds a valid bundle (same cycle as o_valid).
- pr_cancel  in  1  predecode detected a wrong fetch path.
- pr_target  in  32  corrected PC from predecode.
- stall  in  1  instruction queue full; no new requests.
- ic_req  out  1  fetch request.
- ic_addr  out  32  fetch address, bits [3:0]=0 except the first fetch after a redirect.
- ic_ack  in  1  I-cache accepted the request this cycle.
- ic_rvalid  in  1  I-cache returns a bundle (in order).
- o_valid  out  1  bundle forwarded to predecode (i_valid).
- o_busy  out  1  outstanding count nonzero.
- perf_redir_be  out  32  count of backend redirects taken.
- perf_redir_pr  out  32  count of predecode redirects taken.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state=BOOT, pc=RESET_PC, out_cnt=0, drop_cnt=0, perf counters 0.
  - ic_req=0, o_valid=0, o_busy=0, ic_addr=RESET_PC.
- States:
  - BOOT: exactly one cycle after reset deasserts; no request is issued; next state RUN.
  - RUN: requests may issue.
  - HOLD: entered when stall=1; returns to RUN the cycle after stall=0.
  - Redirects are accepted in every state except BOOT. A redirect in BOOT is ignored.
- Redirect selection:
  - redir_be = be_flush.
  - redir_pr = pr_valid & pr_cancel & o_valid & !be_flush.
  - When both fire, be_flush wins.
- Request issue:
  - ic_req = (state==RUN) & !stall & (out_cnt<MAX_OUT) & !redir_be & !redir_pr. Request is suppressed in any redirect cycle.
  - ic_addr = pc, driven combinationally from the pc register.
  - On ic_req&ic_ack: pc <= {pc[31:4]+1, 4'h0}. Carry wraps from 32'hfffffff0 to 0.
- Redirect action in cycle t:
  - pc <= target, selected by priority.
  - drop_cnt <= out_cnt - ic_rvalid, i.e. every request still outstanding after this cycle is wrong-path.
  - The response arriving in cycle t is handled by the normal delivery rule.
  - The matching perf counter increments.
  - The first request to the new target issues at t+1 if the issue conditions hold.
- Delivery:
  - o_valid = ic_rvalid & (drop_cnt==0) & (state!=BOOT).
  - When ic_rvalid & drop_cnt!=0: drop_cnt decrements and o_valid=0.
- Counters:
  - out_cnt_next = out_cnt + (ic_req&ic_ack) - ic_rvalid.
  - Simultaneous accept and return leaves out_cnt unchanged.
  - Never exceeds MAX_OUT. Underflow (ic_rvalid with out_cnt=0) is an assertion failure.
  - A redirect combined with drop_cnt already nonzero overwrites drop_cnt with the new value. The new value is a superset, so this is correct.
- Stall does not block redirects or response draining. A pc update during HOLD takes effect when requests resume.
- Reset mid-operation clears all counters. The I-cache shares this reset, so no stale responses arrive afterwards.
- Perf counters wrap at 2^32.

Decomposition:
- Package gs232c_fetch_pkg holds:
  - the state enum (BOOT, RUN, HOLD);
  - FETCH_BYTES=16;
  - the default RESET_PC.
- Sub-module gs232c_fetch_out_cnt holds the outstanding counter and drop counter pair.
  - Inputs: issue, ret, redirect.
  - Outputs: out_cnt, drop_zero, full.

Test Plan:
- Reset release, ic_ack always 1, stall=0:
  - no ic_req in the BOOT cycle;
  - then ic_addr sequence 1c000000, 1c000010, 1c000020.
- ic_rvalid held off, ic_ack=1: after 4 accepts out_cnt=4 and ic_req=0; one ic_rvalid re-enables ic_req next cycle.
- 3 outstanding, then pr_cancel with o_valid and pr_target=1c000104:
  - 2 later responses dropped (o_valid=0);
  - next ic_addr=1c000104, then 1c000110;
  - perf_redir_pr=1.
- be_flush (be_target=1c008000) and pr_cancel in the same cycle: ic_addr=1c008000, perf_redir_be=1, perf_redir_pr=0.
- stall=1 for 5 cycles with be_flush during the stall: no ic_req during the stall; the first request after the stall uses the be_target address.
- Assert reset while 2 requests are outstanding: all outputs return to reset values immediately; ic_addr=RESET_PC one cycle after release.

Source files
------------

// File: rtl/gs232c_fetch_pkg.sv
// Shared types and constants for the gs232c fetch-PC sequencer.
// The helper advances a PC to the start of the next 16-byte bundle, wrapping at 2^32.
package gs232c_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_BYTES      = 16;
  localparam int unsigned OFS_W            = $clog2(FETCH_BYTES);
  localparam int unsigned HI_W             = 32 - OFS_W;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

  function automatic logic [31:0] next_bundle_pc(input logic [31:0] pc);
    logic [HI_W-1:0] hi;
    hi = pc[31:OFS_W] + HI_W'(1);
    return {hi, {OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/gs232c_fetch_out_cnt.sv
// Outstanding-request counter plus wrong-path drop counter; both update one cycle after their inputs.
// A redirect marks every request still in flight after this cycle as one to discard.
module gs232c_fetch_out_cnt #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  input  logic             ret_i,
  input  logic             redirect_i,
  output logic [CNT_W-1:0] out_cnt_o,
  output logic             drop_zero_o,
  output logic             full_o
);

  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (issue_i && !ret_i) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (!issue_i && ret_i) begin
      out_cnt_d = out_cnt_q - CNT_W'(1);
    end

    // Overwriting a nonzero drop count is safe: the new value covers the old set.
    drop_cnt_d = drop_cnt_q;
    if (redirect_i) begin
      drop_cnt_d = out_cnt_q - CNT_W'(ret_i);
    end else if (ret_i && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_cnt_o   = out_cnt_q;
  assign drop_zero_o = (drop_cnt_q == '0);
  assign full_o      = (out_cnt_q >= CNT_W'(MAX_OUT));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(ret_i && (out_cnt_q == '0)));

endmodule

// File: rtl/gs232c_fetch_redirect_ctrl.sv
// Fetch-PC sequencer: ic_req/ic_addr are combinational from state and pc; redirects land next cycle.
// Stall or a full outstanding window blocks requests, never redirects or response draining.
module gs232c_fetch_redirect_ctrl
  import gs232c_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned MAX_OUT  = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        be_flush,
  input  logic [31:0] be_target,
  input  logic        pr_valid,
  input  logic        pr_cancel,
  input  logic [31:0] pr_target,
  input  logic        stall,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ack,
  input  logic        ic_rvalid,
  output logic        o_valid,
  output logic        o_busy,
  output logic [31:0] perf_redir_be,
  output logic [31:0] perf_redir_pr
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      perf_be_q, perf_pr_q;
  logic [CNT_W-1:0] out_cnt;
  logic             drop_zero, full;
  logic             redir_be, redir_pr, issue;

  assign o_valid  = ic_rvalid & drop_zero & (state_q != ST_BOOT);
  assign redir_be = be_flush & (state_q != ST_BOOT);
  assign redir_pr = pr_valid & pr_cancel & o_valid & ~be_flush;
  assign ic_req   = (state_q == ST_RUN) & ~stall & ~full & ~redir_be & ~redir_pr;
  assign issue    = ic_req & ic_ack;
  assign ic_addr  = pc_q;
  assign o_busy   = (out_cnt != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (stall) state_d = ST_HOLD;
      ST_HOLD: if (!stall) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redir_be) begin
      pc_d = be_target;
    end else if (redir_pr) begin
      pc_d = pr_target;
    end else if (issue) begin
      pc_d = next_bundle_pc(pc_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      perf_be_q <= '0;
      perf_pr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redir_be) perf_be_q <= perf_be_q + 32'd1;
      if (redir_pr) perf_pr_q <= perf_pr_q + 32'd1;
    end
  end

  assign perf_redir_be = perf_be_q;
  assign perf_redir_pr = perf_pr_q;

  gs232c_fetch_out_cnt #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_out_cnt (
    .clk_i       (clock),
    .rst_i       (reset),
    .issue_i     (issue),
    .ret_i       (ic_rvalid),
    .redirect_i  (redir_be | redir_pr),
    .out_cnt_o   (out_cnt),
    .drop_zero_o (drop_zero),
    .full_o      (full)
  );

endmodule
